// File: rtl/half_sub_311.sv
// half_sub_311: registered 1-bit half subtractor with valid qualifier and saturating borrow counter
module half_sub_311 #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             x_311,
   input  logic             y_311,
   output logic             d_311,
   output logic             b_311,
   output logic             out_valid,
   output logic [CNT_W-1:0] borrow_cnt
);
   logic d_q, d_d, b_q, b_d, v_q, v_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   always_comb begin
      d_d   = in_valid ? x_311 ^ y_311 : d_q;
      b_d   = in_valid ? ~x_311 & y_311 : b_q;
      v_d   = in_valid;
      cnt_d = (in_valid && !x_311 && y_311 && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         d_q   <= 1'b0;
         b_q   <= 1'b0;
         v_q   <= 1'b0;
         cnt_q <= '0;
      end else begin
         d_q   <= d_d;
         b_q   <= b_d;
         v_q   <= v_d;
         cnt_q <= cnt_d;
      end
   end
   assign d_311      = d_q;
   assign b_311      = b_q;
   assign out_valid  = v_q;
   assign borrow_cnt = cnt_q;
endmodule

// File: tb/tb_half_sub_311.sv
// tb_half_sub_311: random and directed stimulus against an arithmetic reference model, scoreboard-checked
module tb_half_sub_311;
   logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, x = 1'b0, y = 1'b0;
   logic d8, b8, v8, d2, b2, v2;
   logic [7:0] cnt8;
   logic [1:0] cnt2;
   int checks = 0, fails = 0;
   int m_c8 = 0, m_c2 = 0;
   typedef struct {bit d; bit b; int c8; int c2;} exp_t;
   exp_t q[$];

   half_sub_311 #(.CNT_W(8)) dut8 (.clk(clk), .rst(rst), .in_valid(in_valid), .x_311(x), .y_311(y),
      .d_311(d8), .b_311(b8), .out_valid(v8), .borrow_cnt(cnt8));
   half_sub_311 #(.CNT_W(2)) dut2 (.clk(clk), .rst(rst), .in_valid(in_valid), .x_311(x), .y_311(y),
      .d_311(d2), .b_311(b2), .out_valid(v2), .borrow_cnt(cnt2));

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: difference and borrow from signed integer subtraction; counters saturate by min()
   task automatic drive(input bit r, input bit v, input int xi, input int yi);
      exp_t e;
      int diff;
      @(negedge clk);
      rst = r; in_valid = v; x = xi[0]; y = yi[0];
      if (r) begin
         m_c8 = 0; m_c2 = 0;
      end else if (v) begin
         diff = xi - yi;
         e.d = (diff != 0);
         e.b = (diff < 0);
         if (e.b) begin
            m_c8 = (m_c8 + 1 > 255) ? 255 : m_c8 + 1;
            m_c2 = (m_c2 + 1 > 3) ? 3 : m_c2 + 1;
         end
         e.c8 = m_c8; e.c2 = m_c2;
         q.push_back(e);
      end
   endtask

   // Monitor: decoupled from stimulus, pops an expectation whenever a fresh result appears
   initial begin
      exp_t last, e;
      bit r, v;
      last = '{d: 0, b: 0, c8: 0, c2: 0};
      forever begin
         @(posedge clk);
         r = rst; v = in_valid;
         #1;
         if (r) begin
            chk("reset_d", d8, 0); chk("reset_b", b8, 0);
            chk("reset_valid", v8, 0); chk("reset_cnt8", cnt8, 0); chk("reset_cnt2", cnt2, 0);
            last = '{d: 0, b: 0, c8: 0, c2: 0};
         end else if (v8 || v2) begin
            chk("valid_pair", v2, v8);
            if (q.size() == 0) chk("unexpected_result", 1, 0);
            else begin
               e = q.pop_front();
               chk("diff", d8, e.d); chk("borrow", b8, e.b);
               chk("diff_w2", d2, e.d); chk("borrow_w2", b2, e.b);
               chk("cnt8", cnt8, e.c8); chk("cnt2", cnt2, e.c2);
               last = e;
            end
         end else begin
            chk("no_valid", v, 0);
            chk("hold_d", d8, last.d); chk("hold_b", b8, last.b);
            chk("hold_cnt8", cnt8, last.c8); chk("hold_cnt2", cnt2, last.c2);
         end
      end
   end

   initial begin
      drive(1, 0, 0, 0);
      drive(1, 0, 0, 0);
      for (int i = 0; i < 4; i++) drive(0, 1, i >> 1, i & 1);
      drive(0, 1, 0, 1);
      for (int i = 0; i < 3; i++) drive(0, 0, i & 1, ~i & 1);
      for (int i = 0; i < 5; i++) begin
         drive(0, 1, 0, 1);
         drive(0, 1, 1, 1);
      end
      drive(1, 1, 0, 1);
      drive(0, 0, 0, 1);
      for (int i = 0; i < 6; i++) drive(0, 1, 0, 1);
      for (int i = 0; i < 300; i++)
         drive($urandom_range(0, 29) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 1));
      for (int i = 0; i < 260; i++) drive(0, 1, 0, 1);
      for (int i = 0; i < 20; i++)
         drive(0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
      drive(0, 0, 0, 0);
      drive(0, 0, 0, 0);
      chk("queue_drained", q.size(), 0);
      chk("final_cnt8", cnt8, m_c8);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
